// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Optional MTHI/MTLO write port enabled by defining MDU_HILO_WRITE_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef MDU_HILO_WRITE_EN
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;

    logic             idle;
    logic             accept;
    logic             b_zero;
    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // The done cycle sits in IDLE but still counts as busy, so starts there are ignored.
    assign idle      = (state == IDLE) && !done_o;
    assign accept    = idle && start_i;
    assign b_zero    = op_i[1] && (b_i == '0);
    assign is_signed = ~op_i[0];
    assign a_abs     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign busy_o    = (state != IDLE) || done_o;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   prod_fix;

    // acc:q holds partial product (multiply) or remainder:dividend/quotient (divide)
    assign mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, m};
    assign prod_fix  = neg_q ? -{acc, q} : {acc, q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = b_zero ? FIX : RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
            q             <= '0;
            m             <= '0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
        end else begin
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= op_i[1];
                        neg_q  <= is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_r  <= is_signed && a_i[WIDTH-1];
                        dz     <= b_zero;
                        cnt    <= '0;
                        acc    <= b_zero ? a_i : '0;
                        if (op_i[1]) begin
                            q <= a_abs;
                            m <= b_abs;
                        end else begin
                            q <= b_abs;
                            m <= a_abs;
                        end
                    end
`ifdef MDU_HILO_WRITE_EN
                    else if (idle) begin
                        if (hi_we_i) hi_o <= wdata_i;
                        if (lo_we_i) lo_o <= wdata_i;
                    end
`endif
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        if (!div_trial[WIDTH+1]) begin
                            acc <= div_trial[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[WIDTH-1:0];
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_o        <= 1'b1;
                    div_by_zero_o <= dz;
                    if (dz) begin
                        hi_o <= acc;
                        lo_o <= '1;
                    end else if (is_div) begin
                        lo_o <= neg_q ? -q : q;
                        hi_o <= neg_r ? -acc : acc;
                    end else begin
                        {hi_o, lo_o} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
